pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. Drives the enable and flush controls of the PC and the four pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB) from three hazard sources, in priority order: data-memory wait handshake, taken branch/jump redirect, and load-use dependency. It also keeps saturating performance counters and a sticky memory-timeout flag.

## Interface
- FLUSH_DEPTH, 1: extra cycles IF/ID is flushed after a redirect, to cover instruction-memory latency; legal range 0..7.
- MAX_WAIT, 16: number of consecutive memory-stall cycles that sets mem_timeout; legal range ≥ 2.
- CNT_W, 32: width of the performance counters.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- ifid_rs1 / ifid_rs2  in  5 each  source register fields of the instruction in IF/ID.
- idex_memread  in  1  ID/EX holds a load.
- idex_rd  in  5  destination register held in ID/EX.
- ex_branch_taken  in  1  EX resolves a taken branch, jal or jalr this cycle.
- exmem_mem_req  in  1  EX/MEM holds a load or store (MemRead | MemWrite).
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all control bits 0) on the next edge; flush overrides data but requires the matching _en.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  CNT_W  count of cycles with pc_en = 0.
- flush_cnt  out  CNT_W  count of accepted redirects.

## Operation
- Combinational terms:
  - mem_stall = exmem_mem_req & ~dmem_ready
  - load_use = idex_memread & (idex_rd ≠ 0) & (idex_rd == ifid_rs1 | idex_rd == ifid_rs2)
- Priority 1, mem_stall (any state):
  - pc_en = ifid_en = idex_en = exmem_en = 0.
  - memwb_en = 1 and memwb_flush = 1, so WB receives a bubble and no register is written twice.
  - ex_branch_taken is ignored while stalled. ID/EX is frozen, so the branch remains pending and is acted on in the first non-stalled cycle.
- Priority 2, redirect (ex_branch_taken and no mem_stall):
  - All enables = 1; pc_en loads the target.
  - ifid_flush = idex_flush = 1.
  - flush_cnt increments.
  - If FLUSH_DEPTH > 0: go to REDIRECT with rcnt = FLUSH_DEPTH.
- Priority 3, load_use (RUN state only):
  - pc_en = 0, ifid_en = 0.
  - idex_en = 1 with idex_flush = 1.
  - exmem_en = memwb_en = 1.
- Otherwise all enables = 1 and all flushes = 0.
- States:
  - RUN: normal operation.
  - REDIRECT: ifid_flush = 1 each cycle and load_use is suppressed. rcnt decrements on each non-stalled cycle; at rcnt = 1 the state returns to RUN. A new redirect reloads rcnt = FLUSH_DEPTH.
  - MEM_WAIT: entered on any mem_stall cycle. It saves the prior state (RUN or REDIRECT) and holds rcnt. When dmem_ready rises it returns to the saved state in the same cycle; that cycle is evaluated with the normal priority rules.
- Timeout:
  - wcnt counts consecutive mem_stall cycles and clears on any non-stalled cycle.
  - When wcnt reaches MAX_WAIT, mem_timeout sets and stays set until reset. The stall itself continues.
- Counters:
  - stall_cnt increments on every cycle with pc_en = 0.
  - Both counters saturate at all-ones.

## Timing
- Reset (asynchronous): state = RUN, rcnt = 0, wcnt = 0, counters = 0, mem_timeout = 0.
  - While reset is high: all enables = 0 and all flushes = 0.
- All control outputs are combinational from state and the current-cycle inputs, with zero latency, and take effect at the next rising edge.
- mem_timeout and the counters are registered; they update one edge after the triggering condition.
- A load-use hazard costs exactly 1 stall cycle: the dependent instruction reaches EX one cycle late.
- A redirect costs 1 + FLUSH_DEPTH bubbles in IF/ID.
- A memory wait costs one frozen cycle per cycle of dmem_ready = 0.
- Reset asserted in REDIRECT or MEM_WAIT aborts immediately; after release, operation resumes in RUN with counters at 0.

## Test plan
- Load-use detection:
  - idex_memread = 1, idex_rd = 5, ifid_rs2 = 5 → one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; stall_cnt = 1.
  - Same with idex_rd = 0 → no stall.
- Redirect, FLUSH_DEPTH = 2: ex_branch_taken for 1 cycle → ifid_flush high for 3 cycles, idex_flush high for 1 cycle, flush_cnt = 1, back in RUN after 3 cycles.
- Memory wait: exmem_mem_req = 1 with dmem_ready low for 3 cycles, then high → 3 cycles with pc_en = ifid_en = idex_en = exmem_en = 0 and memwb_flush = 1; stall_cnt = 3; normal enables on the ready cycle.
- Simultaneous events: mem_stall, ex_branch_taken and load_use all asserted → freeze only. After dmem_ready rises, the redirect flush occurs and load_use is ignored.
- Timeout, MAX_WAIT = 4: dmem_ready low for 6 cycles → mem_timeout rises after the 4th stalled cycle and stays 1 after ready returns, until reset.
- Mid-operation reset: assert reset in REDIRECT with rcnt = 2 and counters nonzero → all outputs take reset values immediately; after release, state = RUN and no residual flush.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the five-stage pipeline.
// Resolves memory-wait, redirect and load-use hazards in that priority order.
// Keeps saturating stall/redirect counters and a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
  parameter int FLUSH_DEPTH = 1,
  parameter int MAX_WAIT    = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             ex_branch_taken,
  input  logic             exmem_mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {RUN, REDIRECT, MEM_WAIT} state_t;

  state_t         state_reg;
  state_t         saved_reg;
  state_t         eff_state;
  logic [2:0]     rcnt_reg;
  logic [WW-1:0]  wcnt_reg;
  logic           timeout_reg;
  logic           mem_stall;
  logic           load_use;
  logic           redirect_accept;
  logic [1:0]     cnt_inc;

  assign mem_stall = exmem_mem_req & ~dmem_ready;
  assign load_use  = idex_memread & (idex_rd != 5'd0) &
                     ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

  // The cycle memory becomes ready is judged as if we were already back in
  // the state saved on entry to MEM_WAIT.
  assign eff_state = (state_reg == MEM_WAIT) ? saved_reg : state_reg;

  assign redirect_accept = ~mem_stall & ex_branch_taken;

  // Control outputs: zero-latency decode of state and current hazards.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        // Freeze everything up to EX/MEM; WB gets a bubble so nothing retires twice.
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
      end else if (ex_branch_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use && eff_state == RUN) begin
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = (eff_state == REDIRECT);
      end
    end
  end

  // Sequencer state: redirect shadow countdown and memory-wait save/restore.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      saved_reg <= RUN;
      rcnt_reg  <= 3'd0;
    end else if (mem_stall) begin
      state_reg <= MEM_WAIT;
      if (state_reg != MEM_WAIT) begin
        saved_reg <= state_reg;
      end
    end else if (ex_branch_taken) begin
      if (FLUSH_DEPTH > 0) begin
        state_reg <= REDIRECT;
        rcnt_reg  <= 3'(FLUSH_DEPTH);
      end else begin
        state_reg <= RUN;
        rcnt_reg  <= 3'd0;
      end
    end else if (eff_state == REDIRECT) begin
      if (rcnt_reg <= 3'd1) begin
        state_reg <= RUN;
        rcnt_reg  <= 3'd0;
      end else begin
        state_reg <= REDIRECT;
        rcnt_reg  <= rcnt_reg - 3'd1;
      end
    end else begin
      state_reg <= RUN;
    end
  end

  // Consecutive memory-stall counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_reg    <= '0;
      timeout_reg <= 1'b0;
    end else if (mem_stall) begin
      if (wcnt_reg != WW'(MAX_WAIT)) begin
        wcnt_reg <= wcnt_reg + 1'b1;
      end
      if (wcnt_reg >= WW'(MAX_WAIT - 1)) begin
        timeout_reg <= 1'b1;
      end
    end else begin
      wcnt_reg <= '0;
    end
  end

  assign mem_timeout = timeout_reg;

  // Index 0 counts PC stall cycles, index 1 counts accepted redirects.
  assign cnt_inc = {redirect_accept, ~pc_en};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    // Saturating performance counter.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt = g_cnt[0].cnt_reg;
  assign flush_cnt = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl with FLUSH_DEPTH=2, MAX_WAIT=4.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush}
  localparam logic [7:0] N  = 8'b11111_000;
  localparam logic [7:0] LU = 8'b00111_010;
  localparam logic [7:0] RD = 8'b11111_110;
  localparam logic [7:0] RF = 8'b11111_100;
  localparam logic [7:0] FR = 8'b00001_001;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [7:0] ctl;
    logic       to;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic idex_memread = 1'b0, ex_branch_taken = 1'b0;
  logic exmem_mem_req = 1'b0, dmem_ready = 1'b1;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  vec_t sb[$];
  vec_t tbl[27];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_DEPTH(2), .MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ex_branch_taken(ex_branch_taken),
    .exmem_mem_req(exmem_mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic mr,
                              logic [4:0] rd, logic br, logic req, logic rdy,
                              logic [7:0] ctl, logic to);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.mr = mr; v.rd = rd;
    v.br = br; v.req = req; v.rdy = rdy; v.ctl = ctl; v.to = to;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] ctl_now();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush};
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare at the falling edge.
  task automatic apply(input string name, input vec_t v);
    vec_t e;
    ifid_rs1 = v.rs1; ifid_rs2 = v.rs2; idex_memread = v.mr; idex_rd = v.rd;
    ex_branch_taken = v.br; exmem_mem_req = v.req; dmem_ready = v.rdy;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk({name, ".ctl"}, 32'(ctl_now()), 32'(e.ctl));
    chk({name, ".stall_cnt"}, stall_cnt, 32'(exp_stall));
    chk({name, ".flush_cnt"}, flush_cnt, 32'(exp_flush));
    chk({name, ".timeout"}, 32'(mem_timeout), 32'(e.to));
    $display("txn %s ctl=%b stall_cnt=%0d flush_cnt=%0d to=%b",
             name, ctl_now(), stall_cnt, flush_cnt, mem_timeout);
    if (!e.ctl[7]) exp_stall++;
    if (e.ctl == RD) exp_flush++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rs1, rs2, memread, rd, br, req, rdy, expected ctl, expected timeout
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 1, N,  0);
    tbl[1]  = mk(0, 5, 1, 5, 0, 0, 1, LU, 0);  // load-use on rs2
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, N,  0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 1, N,  0);  // rd = x0 never stalls
    tbl[4]  = mk(7, 0, 1, 7, 0, 0, 1, LU, 0);  // load-use on rs1
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, 1, RD, 0);  // redirect
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, RF, 0);
    tbl[7]  = mk(5, 0, 1, 5, 0, 0, 1, RF, 0);  // load-use suppressed in REDIRECT
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, N,  0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, FR, 0);  // 3-cycle memory wait
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, FR, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, FR, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 1, N,  0);
    tbl[13] = mk(5, 0, 1, 5, 1, 1, 0, FR, 0);  // all three hazards: freeze only
    tbl[14] = mk(5, 0, 1, 5, 1, 1, 0, FR, 0);
    tbl[15] = mk(5, 0, 1, 5, 1, 1, 1, RD, 0);  // ready: redirect wins over load-use
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, RF, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 1, RF, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, N,  0);
    tbl[19] = mk(0, 0, 0, 0, 1, 0, 1, RD, 0);  // stall inside REDIRECT holds rcnt
    tbl[20] = mk(0, 0, 0, 0, 0, 1, 0, FR, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 1, 1, RF, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 1, RF, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 1, N,  0);
    tbl[24] = mk(3, 0, 1, 3, 0, 1, 0, FR, 0);  // load-use behind a memory wait
    tbl[25] = mk(3, 0, 1, 3, 0, 1, 1, LU, 0);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 1, N,  0);

    // Reset state
    #3;
    chk("reset.ctl", 32'(ctl_now()), 32'd0);
    chk("reset.stall_cnt", stall_cnt, 32'd0);
    chk("reset.flush_cnt", flush_cnt, 32'd0);
    chk("reset.timeout", 32'(mem_timeout), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      apply($sformatf("row%0d", i), tbl[i]);
    end

    // Timeout: six stalled cycles, flag visible after the fourth edge.
    for (int k = 1; k <= 6; k++) begin
      apply($sformatf("tmo_stall%0d", k), mk(0, 0, 0, 0, 0, 1, 0, FR, (k >= 5)));
    end
    apply("tmo_ready", mk(0, 0, 0, 0, 0, 1, 1, N, 1));
    apply("tmo_hold",  mk(0, 0, 0, 0, 0, 0, 1, N, 1));

    // Mid-operation reset while in REDIRECT with rcnt = 2.
    apply("mrst_branch", mk(0, 0, 0, 0, 1, 0, 1, RD, 1));
    ifid_rs1 = '0; ifid_rs2 = '0; idex_memread = 1'b0; idex_rd = '0;
    ex_branch_taken = 1'b0; exmem_mem_req = 1'b0; dmem_ready = 1'b1;
    #1;
    chk("mrst.pre_ctl", 32'(ctl_now()), 32'(RF));
    reset = 1'b1;
    #1;
    chk("mrst.ctl", 32'(ctl_now()), 32'd0);
    chk("mrst.stall_cnt", stall_cnt, 32'd0);
    chk("mrst.flush_cnt", flush_cnt, 32'd0);
    chk("mrst.timeout", 32'(mem_timeout), 32'd0);
    $display("txn mrst ctl=%b stall_cnt=%0d flush_cnt=%0d to=%b",
             ctl_now(), stall_cnt, flush_cnt, mem_timeout);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    apply("post_rst0", mk(0, 0, 0, 0, 0, 0, 1, N, 0));
    apply("post_rst1", mk(0, 0, 0, 0, 0, 0, 1, N, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
